fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 41 ++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage memory, redirect and decode-side signal bundle
// Optional misalign_err appears only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_stage_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   modport master (
      output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
      output id_opcode, id_funct3, id_funct7,
`ifdef FETCH_MISALIGN_CHECK_EN
      output misalign_err,
`endif
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
      input  id_opcode, id_funct3, id_funct7,
`ifdef FETCH_MISALIGN_CHECK_EN
      input  misalign_err,
`endif
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch stage with one-entry decode buffer
// FETCH_MISALIGN_CHECK_EN: reject misaligned redirects and flag them on a sticky misalign_err.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master bus
);
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pend_pc;
   logic [31:0] instr_q;
   logic [31:0] id_pc_q;
   logic        req_valid_q;
   logic        id_valid_q;
   logic        accept;
   logic        redir;
   logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic        err_q;
   assign redir    = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
   assign redir_pc = bus.redirect_pc;
   assign bus.misalign_err = err_q;
`else
   logic        unused_redir_lsbs;
   assign unused_redir_lsbs = ^bus.redirect_pc[1:0];
   assign redir    = bus.redirect_valid;
   assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
`endif

   assign accept = req_valid_q && bus.imem_req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_REQ;
         req_valid_q <= 1'b1;
         pc          <= RESET_PC;
         pend_pc     <= 32'h0000_0000;
         instr_q     <= 32'h0000_0013;
         id_pc_q     <= 32'h0000_0000;
         id_valid_q  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
         if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
            err_q <= 1'b1;
         end
`endif
         case (state)
            S_REQ: begin
               if (redir) begin
                  pc         <= redir_pc;
                  id_valid_q <= 1'b0;
                  // An accepted request still owes us a response; swallow it.
                  if (accept) begin
                     state       <= S_DROP;
                     req_valid_q <= 1'b0;
                  end
               end else if (accept) begin
                  pc          <= pc + 32'd4;
                  pend_pc     <= pc;
                  state       <= S_WAIT;
                  req_valid_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (redir) begin
                  pc         <= redir_pc;
                  id_valid_q <= 1'b0;
                  // A response arriving with the redirect is the stale one itself.
                  if (bus.imem_resp_valid) begin
                     state       <= S_REQ;
                     req_valid_q <= 1'b1;
                  end else begin
                     state <= S_DROP;
                  end
               end else if (bus.imem_resp_valid) begin
                  instr_q    <= bus.imem_resp_data;
                  id_pc_q    <= pend_pc;
                  id_valid_q <= 1'b1;
                  state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (redir || bus.id_ready) begin
                  if (redir) begin
                     pc <= redir_pc;
                  end
                  id_valid_q  <= 1'b0;
                  state       <= S_REQ;
                  req_valid_q <= 1'b1;
               end
            end
            S_DROP: begin
               if (redir) begin
                  pc <= redir_pc;
               end
               if (bus.imem_resp_valid) begin
                  state       <= S_REQ;
                  req_valid_q <= 1'b1;
               end
            end
            default: begin
               state       <= S_REQ;
               req_valid_q <= 1'b1;
               id_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = pc;
   assign bus.id_valid       = id_valid_q;
   assign bus.id_instr       = instr_q;
   assign bus.id_pc          = id_pc_q;
   assign bus.id_opcode      = instr_q[6:0];
   assign bus.id_funct3      = instr_q[14:12];
   assign bus.id_funct7      = instr_q[31:25];
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized scoreboard bench for fetch_stage
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_stage_if bus();
   fetch_stage #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   // memory responder and behavioural model state
   int          outstanding = 0;
   logic [31:0] out_addr    = '0;
   int          mem_delay   = 0;
   int          fixed_delay = 0;
   int          max_delay   = 3;
   bit          spurious_en = 0;
   bit          force_en    = 0;
   logic [31:0] force_val   = '0;
   logic [31:0] exp_fetch   = RESET_PC;
   logic [31:0] exp_deliver = RESET_PC;
   logic [31:0] live_pc     = '0;
   bit          live        = 0;
   bit          nv_val      = 0;
   logic [31:0] nv_pc       = '0;
   logic [31:0] nv_instr    = '0;
   bit          exp_err     = 0;
   int          cyc = 0, n_accept = 0, n_deliv = 0;
   logic [31:0] dq_pc[$];
   int          dq_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0020_8033;
      return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
   endfunction

   task automatic model_reset();
      outstanding = 0; mem_delay = 0; live = 0; nv_val = 0; exp_err = 0;
      exp_fetch = RESET_PC; exp_deliver = RESET_PC;
   endtask

   // Response for the cycle that just started: exactly one per accepted request.
   task automatic drive_mem();
      if (outstanding != 0 && mem_delay == 0) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = force_en ? force_val : mem_word(out_addr);
         force_en = 0;
      end else begin
         bus.imem_resp_valid = spurious_en && outstanding == 0 && ($urandom % 8 == 0);
         bus.imem_resp_data  = $urandom;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         drive_mem();
      end
   endtask

   // Compare process: outputs and inputs are both settled at the falling edge.
   logic [31:0] m_reff;
   logic        m_acc, m_redir, m_rv, m_deliv;
   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         cyc++;
         check("id_valid", 32'(bus.id_valid), 32'(nv_val));
         if (nv_val) begin
            check("id_pc", bus.id_pc, nv_pc);
            check("id_instr", bus.id_instr, nv_instr);
            check("id_opcode", 32'(bus.id_opcode), 32'(nv_instr[6:0]));
            check("id_funct3", 32'(bus.id_funct3), 32'(nv_instr[14:12]));
            check("id_funct7", 32'(bus.id_funct7), 32'(nv_instr[31:25]));
         end
         check("imem_req_valid", 32'(bus.imem_req_valid), 32'(nv_val == 1'b0 && outstanding == 0));
         if (bus.imem_req_valid) check("imem_req_addr", bus.imem_req_addr, exp_fetch);
`ifdef FETCH_MISALIGN_CHECK_EN
         check("misalign_err", 32'(bus.misalign_err), 32'(exp_err));
         m_redir = bus.redirect_valid && bus.redirect_pc[1:0] == 2'b00;
         m_reff  = bus.redirect_pc;
         if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) exp_err = 1'b1;
`else
         m_redir = bus.redirect_valid;
         m_reff  = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
         m_acc   = bus.imem_req_valid && bus.imem_req_ready;
         m_rv    = bus.imem_resp_valid && outstanding != 0;
         m_deliv = nv_val && bus.id_ready && !m_redir;
         if (m_acc) begin
            n_accept++;
            check("single_outstanding", 32'(outstanding), 32'd0);
         end
         if (m_deliv) begin
            check("deliver_order", bus.id_pc, exp_deliver);
            dq_pc.push_back(bus.id_pc);
            dq_cyc.push_back(cyc);
            n_deliv++;
         end
         if (m_redir) nv_val = 0;
         else if (live && m_rv) begin
            nv_val = 1; nv_pc = live_pc; nv_instr = bus.imem_resp_data;
         end else if (nv_val && bus.id_ready) nv_val = 0;
         if (m_redir) live = 0;
         else if (m_acc) begin live = 1; live_pc = exp_fetch; end
         else if (m_rv) live = 0;
         if (m_redir) exp_deliver = m_reff;
         else if (m_deliv) exp_deliver = exp_deliver + 32'd4;
         if (m_redir) exp_fetch = m_reff;
         else if (m_acc) exp_fetch = exp_fetch + 32'd4;
         if (m_rv) outstanding = 0;
         else if (outstanding != 0 && mem_delay > 0) mem_delay--;
         if (m_acc) begin
            outstanding = 1;
            out_addr    = bus.imem_req_addr;
            mem_delay   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, max_delay));
         end
      end
   end

   task automatic rand_cycles(input int n);
      int sel;
      for (int i = 0; i < n; i++) begin
         bus.imem_req_ready = ($urandom % 10) < 7;
         bus.id_ready       = ($urandom % 10) < 6;
         bus.redirect_valid = ($urandom % 32) == 0;
         sel = int'($urandom % 4);
         case (sel)
            0: bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
            1: bus.redirect_pc = 32'hFFFF_FFF0 + 32'(4 * ($urandom % 4));
            2: bus.redirect_pc = $urandom;
            default: bus.redirect_pc = 32'h0000_0100;
         endcase
         step(1);
      end
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int          na, d0;
      rst_n = 1'b0;
      bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
      bus.redirect_valid = 0; bus.redirect_pc = 0; bus.id_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("rst_req_addr", bus.imem_req_addr, RESET_PC);
      check("rst_id_valid", 32'(bus.id_valid), 32'd0);
      check("rst_id_instr", bus.id_instr, 32'h0000_0013);
      check("rst_id_pc", bus.id_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_misalign_err", 32'(bus.misalign_err), 32'd0);
`endif
      // first fetch with one-cycle response
      rst_n = 1'b1;
      fixed_delay = 0;
      bus.imem_req_ready = 1'b1;
      check("first_req_addr", bus.imem_req_addr, RESET_PC);
      step(2);
      check("first_id_valid", 32'(bus.id_valid), 32'd1);
      check("first_id_pc", bus.id_pc, 32'h0);
      check("first_opcode", 32'(bus.id_opcode), 32'h33);
      check("first_funct3", 32'(bus.id_funct3), 32'h0);
      check("first_funct7", 32'(bus.id_funct7), 32'h0);

      // back-to-back fetches drain at one per three cycles
      dq_pc.delete(); dq_cyc.delete();
      bus.id_ready = 1'b1;
      step(7);
      check("b2b_count", 32'(dq_pc.size()), 32'd3);
      if (dq_pc.size() == 3) begin
         check("b2b_pc0", dq_pc[0], 32'h0);
         check("b2b_pc1", dq_pc[1], 32'h4);
         check("b2b_pc2", dq_pc[2], 32'h8);
         check("b2b_gap1", 32'(dq_cyc[1] - dq_cyc[0]), 32'd3);
         check("b2b_gap2", 32'(dq_cyc[2] - dq_cyc[1]), 32'd3);
      end

      // decode stall holds the buffer and blocks new requests
      bus.id_ready = 1'b0;
      for (int i = 0; i < 20 && !bus.id_valid; i++) step(1);
      check("stall_id_valid", 32'(bus.id_valid), 32'd1);
      check("stall_id_pc", bus.id_pc, 32'hC);
      na = n_accept;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
      end
      check("stall_id_pc_end", bus.id_pc, 32'hC);
      check("stall_no_accept", 32'(n_accept - na), 32'd0);

      // redirect while waiting; stale response must be discarded
      bus.id_ready = 1'b1;
      step(1);
      fixed_delay = 1;
      step(1);
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
      force_en = 1; force_val = 32'h0000_0013;
      step(1);
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b0;
      check("stale_resp_driven", 32'(bus.imem_resp_valid), 32'd1);
      step(1);
      check("redir_id_valid", 32'(bus.id_valid), 32'd0);
      check("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("redir_req_addr", bus.imem_req_addr, 32'h0000_0100);
      step(1);
      check("redir_id_valid2", 32'(bus.id_valid), 32'd0);

      // address wrap at the top of the space
      fixed_delay = 0;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
      step(1);
      bus.redirect_valid = 1'b0;
      check("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1;
      step(1);
      for (int i = 0; i < 10 && !bus.imem_req_valid; i++) step(1);
      check("wrap_next_addr", bus.imem_req_addr, 32'h0000_0000);
      bus.imem_req_ready = 1'b0;

      // misaligned redirect
      a = bus.imem_req_addr;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102;
      step(1);
      bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      check("misalign_set", 32'(bus.misalign_err), 32'd1);
      check("misalign_pc_kept", bus.imem_req_addr, a);
`else
      check("misalign_forced", bus.imem_req_addr, 32'h0000_0100);
`endif

      // randomized traffic against the scoreboard
      fixed_delay = -1; max_delay = 3; spurious_en = 1;
      d0 = n_deliv;
      rand_cycles(3000);
      check("random_progress", 32'(n_deliv - d0 > 50), 32'd1);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("misalign_sticky", 32'(bus.misalign_err), 32'd1);
`endif

      // asynchronous reset in the middle of traffic
      spurious_en = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("mid_rst_req_addr", bus.imem_req_addr, RESET_PC);
      check("mid_rst_id_valid", 32'(bus.id_valid), 32'd0);
      check("mid_rst_id_instr", bus.id_instr, 32'h0000_0013);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("mid_rst_misalign", 32'(bus.misalign_err), 32'd0);
`endif
      bus.imem_resp_valid = 0; bus.redirect_valid = 0; bus.imem_req_ready = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("post_rst_req_addr", bus.imem_req_addr, RESET_PC);
      spurious_en = 1;
      d0 = n_deliv;
      rand_cycles(500);
      check("post_rst_progress", 32'(n_deliv - d0 > 5), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
